id_ex_alu_issue: RTL and testbench
==================================

Name: id_ex_alu_issue

Overview:
- Producer side of the ALU interface: decodes the RV32I instruction in ID and builds the ALU operands and the 4-bit ALU control code.
- Registers them, with writeback/control side-band, into the ID/EX pipeline register that feeds the EX-stage ALU.
- Handles pipeline stall (hold), flush (bubble) and illegal-instruction marking.
- Single-cycle issue; one instruction per clock when not stalled.

Parameters:
XLEN, 32, datapath width (fixed at 32; parameterised only for readability)
ILLEGAL_CTRL, 4'b0000, ALU control value driven for bubbles and illegal instructions

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hold ID/EX register contents
flush  input  1  replace next ID/EX contents with a bubble
id_valid  input  1  inst/pc/rs data in ID are valid
inst  input  32  instruction word in ID
pc  input  32  PC of instruction in ID
rs1_data  input  32  register-file read port 1 (already forwarded)
rs2_data  input  32  register-file read port 2 (already forwarded)
ex_valid  output  1  EX slot holds a real instruction
ex_alu_a  output  32  ALU operand A
ex_alu_b  output  32  ALU operand B
ex_alu_ctrl  output  4  ALU control code
ex_rd  output  5  destination register
ex_reg_write  output  1  writeback enable
ex_illegal  output  1  instruction was illegal
ex_pc  output  32  PC of EX instruction
ex_store_data  output  32  rs2_data carried for stores

Behaviour:
- ALU codes: ADD=0001, SUB=0010, AND=0011, OR=0100, XOR=0101, SLL=0110, SRL=0111, SLT=1000, SLTU=1001, SRA=1010, Ap4 (A+4)=1011, Bout (pass B)=1100.
- Reset: all outputs 0 on the first clk edge with rst=1; ex_alu_ctrl=ILLEGAL_CTRL.
- Edge priority: rst > flush > stall > load.
  - flush=1: bubble (ex_valid=0, ex_reg_write=0, ex_illegal=0, ex_alu_ctrl=0000; operands, ex_rd, ex_pc and ex_store_data=0), regardless of stall.
  - stall=1 (flush=0): all outputs hold.
  - Otherwise load the decoded values. id_valid=0 loads a bubble.
- Latency: one cycle from ID inputs to ex_* outputs.
- Decode, combinational:
  - R-type (0110011):
    - funct3/funct7 map to ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND.
    - funct7 must be 0000000, or 0100000 only for SUB/SRA.
    - A=rs1, B=rs2.
  - I-ALU (0010011):
    - Same map, B = sign-extended imm[11:0].
    - Shifts: B = {27'b0, inst[24:20]}; funct7 rule applies to SLLI/SRLI/SRAI.
  - LUI: Bout, B = {inst[31:12], 12'b0}, A=0.
  - AUIPC: ADD, A=pc, B = {inst[31:12], 12'b0}.
  - JAL/JALR: Ap4, A=pc, B=0 (link value).
  - LOAD/STORE: ADD, A=rs1, B = I-imm or S-imm; STORE has reg_write=0.
  - BRANCH: A=rs1, B=rs2, reg_write=0.
    - BEQ/BNE: SUB.
    - BLT/BGE: SLT.
    - BLTU/BGEU: SLTU.
    - funct3 010/011: illegal.
- reg_write=1 only for R, I-ALU, LUI, AUIPC, JAL, JALR, LOAD, and only when rd≠0.
- Illegal: unlisted opcode, bad funct3/funct7, JALR funct3≠000.
  - Loads ex_valid=1, ex_illegal=1, ex_alu_ctrl=ILLEGAL_CTRL, ex_reg_write=0, ex_pc=pc.
- Arithmetic: immediates are sign-extended to 32 bits; no carries are computed here.
- Reset mid-stall or mid-flush: reset wins, and outputs are 0 the following cycle.

Decomposition:
- Shared package holds:
  - ALU code localparams (shared with the ALU).
  - Opcode constants: OP_R, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_STORE, OP_BRANCH.
  - funct3 constants.
- One sub-module, alu_ctrl_decode: combinational inst → {alu_ctrl, a_sel, b_sel, imm, reg_write, illegal}.
- The top module adds operand muxing and the ID/EX register.

Test Plan:
- add x3,x1,x2 (inst 0x002081B3), rs1=5, rs2=7, id_valid=1 -> next cycle ex_alu_ctrl=0001, A=5, B=7, ex_rd=3, ex_reg_write=1, ex_valid=1.
- srai x5,x1,3 (0x4030D293), rs1=0x80000000 -> ex_alu_ctrl=1010, B=3, ex_rd=5; the same word with bit30=0 gives 0111 (SRLI); bit29 also set gives ex_illegal=1, ctrl 0000.
- lui x1,0x12345 (0x123450B7) -> ex_alu_ctrl=1100, B=0x12345000, ex_reg_write=1; jal x1,+8 (0x008000EF), pc=0x100 -> ctrl=1011, A=0x100, ex_rd=1.
- Load add, then stall=1 for 3 cycles while inst changes -> outputs unchanged; stall=1 and flush=1 together -> next cycle ex_valid=0, ctrl=0000, reg_write=0.
- addi x0,x0,1 (0x00100013) -> ex_valid=1, ex_reg_write=0; opcode 0x0000007F -> ex_illegal=1.
- rst asserted during a valid stream -> all outputs 0 on the next edge; first instruction after rst deasserts appears one cycle later.

Source files
------------

// File: rtl/id_ex_alu_issue_pkg.sv
// id_ex_alu_issue_pkg: constants and types shared by the ID-stage ALU issue logic
// and the EX-stage ALU.
//   - 4-bit ALU control codes
//   - RV32I opcode and funct3/funct7 constants
//   - operand-select enums
//   - a helper that maps funct3 and the funct7 "alt" bit to an ALU code
package id_ex_alu_issue_pkg;

    // ALU control codes
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_AP4  = 4'b1011;  // A + 4, link address
    localparam logic [3:0] ALU_BOUT = 4'b1100;  // pass operand B

    // Major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU funct3
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load/store funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_JALR = 3'b000;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ASelRs1  = 2'd0,
        ASelPc   = 2'd1,
        ASelZero = 2'd2
    } a_sel_e;

    typedef enum logic [1:0] {
        BSelRs2  = 2'd0,
        BSelImm  = 2'd1,
        BSelZero = 2'd2
    } b_sel_e;

    // Register/immediate ALU op from funct3; alt selects SUB/SRA over ADD/SRL.
    function automatic logic [3:0] alu_op_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        unique case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_ex_alu_issue_alu_ctrl_decode.sv
// alu_ctrl_decode: combinational RV32I decode for the ALU issue path.
// Ports:
//   i_inst        instruction word in ID
//   o_alu_ctrl    4-bit ALU control code (ILLEGAL_CTRL when illegal)
//   o_a_sel       operand A select (a_sel_e encoding)
//   o_b_sel       operand B select (b_sel_e encoding)
//   o_imm         sign-extended / shifted immediate for operand B
//   o_reg_write   writeback enable (already qualified with rd != 0)
//   o_illegal     instruction is not a supported RV32I encoding
module alu_ctrl_decode
    import id_ex_alu_issue_pkg::*;
#(
    parameter logic [3:0] ILLEGAL_CTRL = 4'b0000
) (
    input  logic [31:0] i_inst,
    output logic [3:0]  o_alu_ctrl,
    output logic [1:0]  o_a_sel,
    output logic [1:0]  o_b_sel,
    output logic [31:0] o_imm,
    output logic        o_reg_write,
    output logic        o_illegal
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_sh;

    logic [3:0]  w_ctrl;
    a_sel_e      w_a_sel;
    b_sel_e      w_b_sel;
    logic [31:0] w_imm;
    logic        w_writes_rd;
    logic        w_illegal;

    assign w_opcode = i_inst[6:0];
    assign w_f3     = i_inst[14:12];
    assign w_f7     = i_inst[31:25];
    assign w_rd     = i_inst[11:7];
    assign w_imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_u  = {i_inst[31:12], 12'b0};
    assign w_imm_sh = {27'b0, i_inst[24:20]};

    always_comb begin
        w_ctrl      = ILLEGAL_CTRL;
        w_a_sel     = ASelZero;
        w_b_sel     = BSelZero;
        w_imm       = '0;
        w_writes_rd = 1'b0;
        w_illegal   = 1'b0;

        case (w_opcode)
            OP_R: begin
                w_a_sel     = ASelRs1;
                w_b_sel     = BSelRs2;
                w_writes_rd = 1'b1;
                if (w_f7 == F7_BASE) begin
                    w_ctrl = alu_op_from_f3(w_f3, 1'b0);
                end else if (w_f7 == F7_ALT &&
                             (w_f3 == F3_ADD_SUB || w_f3 == F3_SRL_SRA)) begin
                    w_ctrl = alu_op_from_f3(w_f3, 1'b1);
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OP_IMM: begin
                w_a_sel     = ASelRs1;
                w_b_sel     = BSelImm;
                w_writes_rd = 1'b1;
                if (w_f3 == F3_SLL) begin
                    w_imm = w_imm_sh;
                    if (w_f7 == F7_BASE) w_ctrl = ALU_SLL;
                    else                 w_illegal = 1'b1;
                end else if (w_f3 == F3_SRL_SRA) begin
                    w_imm = w_imm_sh;
                    if (w_f7 == F7_BASE)     w_ctrl = ALU_SRL;
                    else if (w_f7 == F7_ALT) w_ctrl = ALU_SRA;
                    else                     w_illegal = 1'b1;
                end else begin
                    // No ADDI/SUBI split: funct7 bits are immediate here
                    w_imm  = w_imm_i;
                    w_ctrl = alu_op_from_f3(w_f3, 1'b0);
                end
            end
            OP_LUI: begin
                w_ctrl      = ALU_BOUT;
                w_a_sel     = ASelZero;
                w_b_sel     = BSelImm;
                w_imm       = w_imm_u;
                w_writes_rd = 1'b1;
            end
            OP_AUIPC: begin
                w_ctrl      = ALU_ADD;
                w_a_sel     = ASelPc;
                w_b_sel     = BSelImm;
                w_imm       = w_imm_u;
                w_writes_rd = 1'b1;
            end
            OP_JAL: begin
                w_ctrl      = ALU_AP4;
                w_a_sel     = ASelPc;
                w_b_sel     = BSelZero;
                w_writes_rd = 1'b1;
            end
            OP_JALR: begin
                if (w_f3 == F3_JALR) begin
                    w_ctrl      = ALU_AP4;
                    w_a_sel     = ASelPc;
                    w_b_sel     = BSelZero;
                    w_writes_rd = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OP_LOAD: begin
                if (w_f3 == F3_LB || w_f3 == F3_LH || w_f3 == F3_LW ||
                    w_f3 == F3_LBU || w_f3 == F3_LHU) begin
                    w_ctrl      = ALU_ADD;
                    w_a_sel     = ASelRs1;
                    w_b_sel     = BSelImm;
                    w_imm       = w_imm_i;
                    w_writes_rd = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OP_STORE: begin
                if (w_f3 == F3_LB || w_f3 == F3_LH || w_f3 == F3_LW) begin
                    w_ctrl  = ALU_ADD;
                    w_a_sel = ASelRs1;
                    w_b_sel = BSelImm;
                    w_imm   = w_imm_s;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                w_a_sel = ASelRs1;
                w_b_sel = BSelRs2;
                case (w_f3)
                    F3_BEQ, F3_BNE:   w_ctrl = ALU_SUB;
                    F3_BLT, F3_BGE:   w_ctrl = ALU_SLT;
                    F3_BLTU, F3_BGEU: w_ctrl = ALU_SLTU;
                    default:          w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase

        // Illegal words carry no operands and never write back
        if (w_illegal) begin
            w_ctrl      = ILLEGAL_CTRL;
            w_a_sel     = ASelZero;
            w_b_sel     = BSelZero;
            w_imm       = '0;
            w_writes_rd = 1'b0;
        end
    end

    assign o_alu_ctrl  = w_ctrl;
    assign o_a_sel     = w_a_sel;
    assign o_b_sel     = w_b_sel;
    assign o_imm       = w_imm;
    assign o_reg_write = w_writes_rd && (w_rd != 5'd0);
    assign o_illegal   = w_illegal;

endmodule

// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue: decodes the RV32I instruction in ID, muxes ALU operands and
// registers them with writeback side-band into the ID/EX pipeline register.
// Edge priority: reset > flush (bubble) > stall (hold) > load.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_stall, i_flush    hold / bubble the ID/EX register
//   i_id_valid          ID inputs are valid (0 loads a bubble)
//   i_inst, i_pc        instruction word and its PC
//   i_rs1_data/rs2_data forwarded register operands
//   o_ex_*              registered EX-stage ALU operands, control and side-band
module id_ex_alu_issue
    import id_ex_alu_issue_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter logic [3:0]  ILLEGAL_CTRL = 4'b0000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_id_valid,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    output logic            o_ex_valid,
    output logic [XLEN-1:0] o_ex_alu_a,
    output logic [XLEN-1:0] o_ex_alu_b,
    output logic [3:0]      o_ex_alu_ctrl,
    output logic [4:0]      o_ex_rd,
    output logic            o_ex_reg_write,
    output logic            o_ex_illegal,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [XLEN-1:0] o_ex_store_data
);

    logic [3:0]      w_alu_ctrl;
    logic [1:0]      w_a_sel;
    logic [1:0]      w_b_sel;
    logic [31:0]     w_imm;
    logic            w_reg_write;
    logic            w_illegal;
    logic [XLEN-1:0] w_alu_a;
    logic [XLEN-1:0] w_alu_b;

    logic            r_valid;
    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;
    logic [3:0]      r_alu_ctrl;
    logic [4:0]      r_rd;
    logic            r_reg_write;
    logic            r_illegal;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_store_data;

    alu_ctrl_decode #(
        .ILLEGAL_CTRL (ILLEGAL_CTRL)
    ) u_decode (
        .i_inst      (i_inst),
        .o_alu_ctrl  (w_alu_ctrl),
        .o_a_sel     (w_a_sel),
        .o_b_sel     (w_b_sel),
        .o_imm       (w_imm),
        .o_reg_write (w_reg_write),
        .o_illegal   (w_illegal)
    );

    always_comb begin
        w_alu_a = '0;
        case (a_sel_e'(w_a_sel))
            ASelRs1: w_alu_a = i_rs1_data;
            ASelPc:  w_alu_a = i_pc;
            default: w_alu_a = '0;
        endcase
    end

    always_comb begin
        w_alu_b = '0;
        case (b_sel_e'(w_b_sel))
            BSelRs2: w_alu_b = i_rs2_data;
            BSelImm: w_alu_b = w_imm;
            default: w_alu_b = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush || (!i_stall && !i_id_valid)) begin
            r_valid      <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= ILLEGAL_CTRL;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_illegal    <= 1'b0;
            r_pc         <= '0;
            r_store_data <= '0;
        end else if (!i_stall) begin
            r_valid      <= 1'b1;
            r_alu_a      <= w_alu_a;
            r_alu_b      <= w_alu_b;
            r_alu_ctrl   <= w_alu_ctrl;
            // Illegal slots keep only the PC so a trap handler can locate them
            r_rd         <= w_illegal ? 5'd0 : i_inst[11:7];
            r_reg_write  <= w_reg_write;
            r_illegal    <= w_illegal;
            r_pc         <= i_pc;
            r_store_data <= w_illegal ? '0 : i_rs2_data;
        end
    end

    assign o_ex_valid      = r_valid;
    assign o_ex_alu_a      = r_alu_a;
    assign o_ex_alu_b      = r_alu_b;
    assign o_ex_alu_ctrl   = r_alu_ctrl;
    assign o_ex_rd         = r_rd;
    assign o_ex_reg_write  = r_reg_write;
    assign o_ex_illegal    = r_illegal;
    assign o_ex_pc         = r_pc;
    assign o_ex_store_data = r_store_data;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench: each driven cycle pushes the hand-computed ID/EX contents
// expected after the next edge; a monitor pops and compares one entry per cycle.
module tb_id_ex_alu_issue;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [31:0] inst, pc, rs1_data, rs2_data;
    logic        ex_valid, ex_reg_write, ex_illegal;
    logic [31:0] ex_alu_a, ex_alu_b, ex_pc, ex_store_data;
    logic [3:0]  ex_alu_ctrl;
    logic [4:0]  ex_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_alu_issue #(
        .XLEN         (32),
        .ILLEGAL_CTRL (4'b0000)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_id_valid      (id_valid),
        .i_inst          (inst),
        .i_pc            (pc),
        .i_rs1_data      (rs1_data),
        .i_rs2_data      (rs2_data),
        .o_ex_valid      (ex_valid),
        .o_ex_alu_a      (ex_alu_a),
        .o_ex_alu_b      (ex_alu_b),
        .o_ex_alu_ctrl   (ex_alu_ctrl),
        .o_ex_rd         (ex_rd),
        .o_ex_reg_write  (ex_reg_write),
        .o_ex_illegal    (ex_illegal),
        .o_ex_pc         (ex_pc),
        .o_ex_store_data (ex_store_data)
    );

    // care[2]: operands A/B, care[1]: rd, care[0]: store data
    typedef struct {
        string       name;
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  c;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
        logic [31:0] pc;
        logic [31:0] sd;
        logic [2:0]  care;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic mon_ok;

    function automatic exp_t mk(input string name, input logic v, input logic [31:0] a,
                                input logic [31:0] b, input logic [3:0] c,
                                input logic [4:0] rd, input logic rw, input logic ill,
                                input logic [31:0] p, input logic [31:0] sd,
                                input logic [2:0] care);
        exp_t e;
        e.name = name; e.v = v; e.a = a; e.b = b; e.c = c; e.rd = rd;
        e.rw = rw; e.ill = ill; e.pc = p; e.sd = sd; e.care = care;
        return e;
    endfunction

    function automatic exp_t bubble(input string name);
        return mk(name, 1'b0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b111);
    endfunction

    function automatic exp_t illegal(input string name, input logic [31:0] p);
        return mk(name, 1'b1, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b1, p, 32'h0, 3'b000);
    endfunction

    task automatic drive(input logic r, input logic s, input logic f, input logic v,
                         input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        rst = r; stall = s; flush = f; id_valid = v;
        inst = i; pc = p; rs1_data = a; rs2_data = b;
    endtask

    task automatic step(input exp_t e);
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every cycle the DUT presents one ID/EX register state
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e  = sb.pop_front();
            mon_ok = (ex_valid == mon_e.v) && (ex_alu_ctrl == mon_e.c) &&
                     (ex_reg_write == mon_e.rw) && (ex_illegal == mon_e.ill) &&
                     (ex_pc == mon_e.pc);
            if (mon_e.care[2]) mon_ok = mon_ok && (ex_alu_a == mon_e.a) && (ex_alu_b == mon_e.b);
            if (mon_e.care[1]) mon_ok = mon_ok && (ex_rd == mon_e.rd);
            if (mon_e.care[0]) mon_ok = mon_ok && (ex_store_data == mon_e.sd);
            n_checks++;
            if (!mon_ok) begin
                n_fail++;
                $display("FAIL %s: got v=%0b a=%h b=%h ctrl=%h rd=%0d rw=%0b ill=%0b pc=%h sd=%h; want v=%0b a=%h b=%h ctrl=%h rd=%0d rw=%0b ill=%0b pc=%h sd=%h care=%b",
                         mon_e.name, ex_valid, ex_alu_a, ex_alu_b, ex_alu_ctrl, ex_rd,
                         ex_reg_write, ex_illegal, ex_pc, ex_store_data, mon_e.v, mon_e.a,
                         mon_e.b, mon_e.c, mon_e.rd, mon_e.rw, mon_e.ill, mon_e.pc, mon_e.sd,
                         mon_e.care);
            end
        end
    end

    initial begin
        // Reset with a valid instruction present
        drive(1, 0, 0, 1, 32'h002081B3, 32'h40, 32'd5, 32'd7);
        step(bubble("reset"));

        drive(0, 0, 0, 1, 32'h002081B3, 32'h40, 32'd5, 32'd7);
        step(mk("add", 1, 32'd5, 32'd7, 4'b0001, 5'd3, 1, 0, 32'h40, 32'd7, 3'b111));

        drive(0, 0, 0, 1, 32'h402081B3, 32'h44, 32'd5, 32'd7);
        step(mk("sub", 1, 32'd5, 32'd7, 4'b0010, 5'd3, 1, 0, 32'h44, 32'd7, 3'b111));

        drive(0, 0, 0, 1, 32'h4030D293, 32'h48, 32'h80000000, 32'd7);
        step(mk("srai", 1, 32'h80000000, 32'd3, 4'b1010, 5'd5, 1, 0, 32'h48, 32'd7, 3'b111));

        drive(0, 0, 0, 1, 32'h0030D293, 32'h4C, 32'h80000000, 32'd7);
        step(mk("srli", 1, 32'h80000000, 32'd3, 4'b0111, 5'd5, 1, 0, 32'h4C, 32'd7, 3'b111));

        drive(0, 0, 0, 1, 32'h6030D293, 32'h50, 32'h80000000, 32'd7);
        step(illegal("srai_bad_f7", 32'h50));

        drive(0, 0, 0, 1, 32'h123450B7, 32'h54, 32'd5, 32'd7);
        step(mk("lui", 1, 32'h0, 32'h12345000, 4'b1100, 5'd1, 1, 0, 32'h54, 32'd7, 3'b111));

        drive(0, 0, 0, 1, 32'h008000EF, 32'h100, 32'd5, 32'd7);
        step(mk("jal", 1, 32'h100, 32'h0, 4'b1011, 5'd1, 1, 0, 32'h100, 32'd7, 3'b111));

        drive(0, 0, 0, 1, 32'h00100013, 32'h104, 32'd5, 32'd7);
        step(mk("addi_x0", 1, 32'd5, 32'd1, 4'b0001, 5'd0, 0, 0, 32'h104, 32'd7, 3'b111));

        drive(0, 0, 0, 1, 32'h0000007F, 32'h108, 32'd5, 32'd7);
        step(illegal("bad_opcode", 32'h108));

        drive(0, 0, 0, 1, 32'h00208063, 32'h10C, 32'd5, 32'd7);
        step(mk("beq", 1, 32'd5, 32'd7, 4'b0010, 5'd0, 0, 0, 32'h10C, 32'd7, 3'b101));

        drive(0, 0, 0, 1, 32'h0020A223, 32'h110, 32'd5, 32'd9);
        step(mk("sw", 1, 32'd5, 32'd4, 4'b0001, 5'd0, 0, 0, 32'h110, 32'd9, 3'b101));

        drive(0, 0, 0, 1, 32'hFFC0A203, 32'h114, 32'd5, 32'd7);
        step(mk("lw_neg", 1, 32'd5, 32'hFFFFFFFC, 4'b0001, 5'd4, 1, 0, 32'h114, 32'd7, 3'b111));

        drive(0, 0, 0, 1, 32'h00001117, 32'h118, 32'd5, 32'd7);
        step(mk("auipc", 1, 32'h118, 32'h1000, 4'b0001, 5'd2, 1, 0, 32'h118, 32'd7, 3'b111));

        // Load an add, then hold it for three cycles while ID changes
        drive(0, 0, 0, 1, 32'h002081B3, 32'h200, 32'd5, 32'd7);
        step(mk("add_pre_stall", 1, 32'd5, 32'd7, 4'b0001, 5'd3, 1, 0, 32'h200, 32'd7, 3'b111));
        drive(0, 1, 0, 1, 32'h402081B3, 32'h204, 32'd9, 32'd11);
        step(mk("stall1", 1, 32'd5, 32'd7, 4'b0001, 5'd3, 1, 0, 32'h200, 32'd7, 3'b111));
        drive(0, 1, 0, 1, 32'h123450B7, 32'h208, 32'd9, 32'd11);
        step(mk("stall2", 1, 32'd5, 32'd7, 4'b0001, 5'd3, 1, 0, 32'h200, 32'd7, 3'b111));
        drive(0, 1, 0, 0, 32'h0000007F, 32'h20C, 32'd9, 32'd11);
        step(mk("stall3", 1, 32'd5, 32'd7, 4'b0001, 5'd3, 1, 0, 32'h200, 32'd7, 3'b111));

        drive(0, 1, 1, 1, 32'h002081B3, 32'h210, 32'd5, 32'd7);
        step(bubble("stall_and_flush"));

        drive(0, 0, 0, 0, 32'h002081B3, 32'h214, 32'd5, 32'd7);
        step(bubble("id_invalid"));

        // Reset in the middle of a valid stream
        drive(0, 0, 0, 1, 32'h002081B3, 32'h300, 32'd5, 32'd7);
        step(mk("add_pre_rst", 1, 32'd5, 32'd7, 4'b0001, 5'd3, 1, 0, 32'h300, 32'd7, 3'b111));
        drive(1, 0, 0, 1, 32'h402081B3, 32'h304, 32'd5, 32'd7);
        step(bubble("rst_mid_stream"));
        drive(0, 0, 0, 1, 32'h123450B7, 32'h308, 32'd5, 32'd7);
        step(mk("lui_after_rst", 1, 32'h0, 32'h12345000, 4'b1100, 5'd1, 1, 0, 32'h308, 32'd7,
                3'b111));

        // Reset wins over stall
        drive(1, 1, 0, 1, 32'h002081B3, 32'h30C, 32'd5, 32'd7);
        step(bubble("rst_mid_stall"));

        drive(0, 0, 0, 1, 32'h000080E7, 32'h400, 32'd5, 32'd7);
        step(mk("jalr", 1, 32'h400, 32'h0, 4'b1011, 5'd1, 1, 0, 32'h400, 32'd7, 3'b111));

        drive(0, 0, 0, 1, 32'h000010E7, 32'h404, 32'd5, 32'd7);
        step(illegal("jalr_bad_f3", 32'h404));

        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'd0, 32'd0);
        step(bubble("final_bubble"));

        // Allow the monitor to drain, bounded
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
